timer_multi_cmp: RTL

Parameterised next-generation SoC timer: WIDTH-bit up-counter driven by a programmable prescaler, period register with wrap or one-shot mode, NUM_CMP independent compare channels, sticky status flags and a masked interrupt. Sits on the SoC peripheral bus beside the existing timer; the register-file wrapper drives control, prescale, period, compare and flag-clear inputs.

---
 rtl/timer_multi_cmp_pkg.sv | 30 +++
 rtl/timer_multi_cmp_prescaler.sv | 39 +++
 rtl/timer_multi_cmp.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/timer_multi_cmp_pkg.sv
// Shared constants for the multi-compare timer: control bit positions and flag vector layout.
// Flag width grows by one "cap" bit when TIMER_CAPTURE_EN is defined.
package timer_multi_cmp_pkg;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_ONESHOT = 2;

  // Flag layout from LSB: cmp[numCmp-1:0], ovf, done, (cap)
  function automatic int flagOvf(input int numCmp);
    return numCmp;
  endfunction

  function automatic int flagDone(input int numCmp);
    return numCmp + 1;
  endfunction

  function automatic int flagCap(input int numCmp);
    return numCmp + 2;
  endfunction

  function automatic int flagWidth(input int numCmp);
`ifdef TIMER_CAPTURE_EN
    return numCmp + 3;
`else
    return numCmp + 2;
`endif
  endfunction

endpackage

// File: rtl/timer_multi_cmp_prescaler.sv
// Prescaler for the multi-compare timer: emits one tick every prescale+1 enabled clocks.
// hold_i freezes the phase (one-shot completed); clear_i restarts it at zero.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  hold_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] prescCnt_q;
  logic [PRESCALE_W-1:0] prescCnt_d;
  logic                  running;

  assign running = enable_i & ~hold_i & ~clear_i;
  assign tick_o  = running & (prescCnt_q == prescale_i);

  always_comb begin
    prescCnt_d = prescCnt_q;
    if (clear_i) begin
      prescCnt_d = '0;
    end else if (running) begin
      prescCnt_d = tick_o ? '0 : prescCnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescCnt_q <= '0;
    end else begin
      prescCnt_q <= prescCnt_d;
    end
  end

endmodule

// File: rtl/timer_multi_cmp.sv
// Multi-channel compare timer: prescaled up-counter with wrap/one-shot, sticky flags, masked irq.
// Define TIMER_CAPTURE_EN to add a synchronised input-capture channel and its "cap" flag.
module timer_multi_cmp
  import timer_multi_cmp_pkg::*;
#(
  parameter int  WIDTH      = 32,
  parameter int  NUM_CMP    = 4,
  parameter int  PRESCALE_W = 16,
  localparam int FW         = flagWidth(NUM_CMP)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               control_reg,
  input  logic [PRESCALE_W-1:0]    prescale,
  input  logic [WIDTH-1:0]         period,
  input  logic [NUM_CMP*WIDTH-1:0] cmp_value,
  input  logic [FW-1:0]            irq_mask,
  input  logic [FW-1:0]            flag_clr,
`ifdef TIMER_CAPTURE_EN
  input  logic                     capture_in,
  output logic [WIDTH-1:0]         capture_value,
`endif
  output logic [WIDTH-1:0]         timer_value,
  output logic [NUM_CMP-1:0]       cmp_match,
  output logic                     ovf_pulse,
  output logic [FW-1:0]            flags,
  output logic                     irq
);

  localparam int FLAG_OVF  = flagOvf(NUM_CMP);
  localparam int FLAG_DONE = flagDone(NUM_CMP);

  logic               enable, clear, oneShot, tick;
  logic               atPeriod, advance;
  logic               unusedCtrl;
  logic [WIDTH-1:0]   cnt_q, cnt_d, cntNext;
  logic [NUM_CMP-1:0] match_q, match_d;
  logic               ovf_q, ovf_d;
  logic               doneLock_q, doneLock_d;
  logic               irq_q, irq_d;
  logic [FW-1:0]      flags_q, flags_d, flagSet;

  assign enable     = control_reg[CTRL_EN];
  assign clear      = control_reg[CTRL_CLR];
  assign oneShot    = control_reg[CTRL_ONESHOT];
  assign unusedCtrl = ^control_reg[7:3];

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clock      (clock),
    .reset      (reset),
    .enable_i   (enable),
    .clear_i    (clear),
    .hold_i     (doneLock_q),
    .prescale_i (prescale),
    .tick_o     (tick)
  );

`ifdef TIMER_CAPTURE_EN
  localparam int FLAG_CAP = flagCap(NUM_CMP);

  // Two synchroniser flops plus a delayed copy for edge detection; only capSync_q[1] feeds logic.
  logic [2:0]       capSync_q;
  logic [WIDTH-1:0] capture_q;
  logic             capRise;

  assign capRise       = capSync_q[1] & ~capSync_q[2];
  assign capture_value = capture_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      capSync_q <= '0;
      capture_q <= '0;
    end else begin
      capSync_q <= {capSync_q[1:0], capture_in};
      if (capRise) begin
        capture_q <= cnt_q;
      end
    end
  end
`endif

  always_comb begin
    atPeriod = (cnt_q == period);
    // Compares fire only when the count actually changes, so a finished one-shot cannot re-match.
    advance  = tick & ~(atPeriod & oneShot);
    cntNext  = cnt_q + WIDTH'(1);
    if (atPeriod) begin
      cntNext = oneShot ? cnt_q : '0;
    end

    cnt_d      = cnt_q;
    doneLock_d = doneLock_q;
    match_d    = '0;
    ovf_d      = 1'b0;
    flagSet    = '0;

    if (clear) begin
      cnt_d      = '0;
      doneLock_d = 1'b0;
    end else if (tick) begin
      cnt_d = cntNext;
      ovf_d = atPeriod & ~oneShot;
      if (atPeriod && oneShot) begin
        doneLock_d         = 1'b1;
        flagSet[FLAG_DONE] = 1'b1;
      end
      for (int i = 0; i < NUM_CMP; i++) begin
        match_d[i] = advance & (cntNext == cmp_value[i*WIDTH +: WIDTH]);
      end
    end

    flagSet[NUM_CMP-1:0] = match_d;
    flagSet[FLAG_OVF]    = ovf_d;
`ifdef TIMER_CAPTURE_EN
    flagSet[FLAG_CAP]    = capRise;
`endif
    // Set beats clear when both land in the same cycle.
    flags_d = (flags_q & ~flag_clr) | flagSet;
    irq_d   = |(flags_q & irq_mask);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      match_q    <= '0;
      ovf_q      <= 1'b0;
      doneLock_q <= 1'b0;
      flags_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      doneLock_q <= doneLock_d;
      flags_q    <= flags_d;
      irq_q      <= irq_d;
    end
  end

  assign timer_value = cnt_q;
  assign cmp_match   = match_q;
  assign ovf_pulse   = ovf_q;
  assign flags       = flags_q;
  assign irq         = irq_q;

endmodule
